// File: rtl/lmem_arbiter.sv
// Round-robin arbiter for the shared layer-memory port of the conv/pool engine.
// Requester 0 = conv (L0 writes), requester 1 = max-pool (L0 reads, L1 writes).
module lmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 20,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        sel0,
  input  logic [2:0]        sel1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              cwr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

  logic              r_last;
  logic [7:0]        r_lock_cnt;
  logic              r_cwr, r_crd, r_rd_id, r_err;
  logic [1:0]        r_rvalid;
  logic [ADDR_W-1:0] r_caddr_wr, r_caddr_rd;
  logic [DATA_W-1:0] r_cdata_wr;
  logic [2:0]        r_csel;

  logic              w_any, w_hold, w_pick1, w_other_req, w_ok;
  logic              w_we, w_wr, w_rd;
  logic [2:0]        w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Last winner keeps the port only while it holds lock and its burst budget lasts.
  assign w_hold  = (r_last ? lock1 : lock0) && (r_lock_cnt < LP_MAX);
  assign w_pick1 = (req0 & req1) ? (w_hold ? r_last : ~r_last) : req1;
  assign w_any   = ~reset & (req0 | req1);

  assign w_other_req = w_pick1 ? req0 : req1;
  assign w_we        = w_pick1 ? we1    : we0;
  assign w_sel       = w_pick1 ? sel1   : sel0;
  assign w_addr      = w_pick1 ? addr1  : addr0;
  assign w_wdata     = w_pick1 ? wdata1 : wdata0;
  assign w_ok        = (w_sel == 3'b001) || (w_sel == 3'b011);
  assign w_wr        = w_any & w_ok & w_we;
  assign w_rd        = w_any & w_ok & ~w_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_cwr      <= 1'b0;
      r_crd      <= 1'b0;
      r_rd_id    <= 1'b0;
      r_caddr_wr <= '0;
      r_caddr_rd <= '0;
      r_cdata_wr <= '0;
      r_csel     <= '0;
      r_rvalid   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cwr      <= w_wr;
      r_crd      <= w_rd;
      r_rd_id    <= w_pick1;
      r_caddr_wr <= w_wr ? w_addr  : '0;
      r_cdata_wr <= w_wr ? w_wdata : '0;
      r_caddr_rd <= w_rd ? w_addr  : '0;
      r_csel     <= (w_any & w_ok) ? w_sel : 3'b000;
      r_rvalid   <= {r_crd & r_rd_id, r_crd & ~r_rd_id};
      r_err      <= r_err | (w_any & ~w_ok);
      if (w_any) begin
        r_last <= w_pick1;
        // Counter holds the length of the current contended run, first grant included.
        if (!w_other_req)
          r_lock_cnt <= '0;
        else if (w_pick1 == r_last)
          r_lock_cnt <= r_lock_cnt + 8'd1;
        else
          r_lock_cnt <= 8'd1;
      end
    end
  end

  assign gnt0     = w_any & ~w_pick1;
  assign gnt1     = w_any & w_pick1;
  assign rvalid0  = r_rvalid[0];
  assign rvalid1  = r_rvalid[1];
  assign rdata0   = cdata_rd;
  assign rdata1   = cdata_rd;
  assign cwr      = r_cwr;
  assign crd      = r_crd;
  assign caddr_wr = r_caddr_wr;
  assign caddr_rd = r_caddr_rd;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;
  assign err      = r_err;
  assign busy     = req0 | req1 | r_cwr | r_crd | (|r_rvalid);

endmodule
